// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the bit-serial word feeder
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_WIDTH_DEF = 8;

  // Bits needed to hold a remaining-bit count of w-1; never narrower than 1.
  function automatic int ser_cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - parallel word to gapless 1-bit stream over valid/ready
// SERIAL_FEEDER_LSB_FIRST_EN selects LSB-first emission; default build is MSB first.
module serial_word_feeder
  import serial_pkg::*;
#(
  parameter int   WIDTH    = SER_WIDTH_DEF,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = ser_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic last_bit;
  logic accept;
  logic cur_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_FEEDER_LSB_FIRST_EN
  assign cur_bit = shreg_q[0];
`else
  assign cur_bit = shreg_q[WIDTH-1];
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    last_bit = (state_q == SHIFT) && (cnt_q == '0);
    // Ready on the last bit lets the next word follow without a bubble.
    din_ready = !reset && ((state_q == IDLE) || last_bit);
    accept    = din_valid && din_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
          shreg_d = shreg_q >> 1;
`else
          shreg_d = shreg_q << 1;
`endif
          cnt_d = cnt_q - 1'b1;
        end else if (accept) begin
          shreg_d = din;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the line idle immediately so a discarded word never leaks a bit.
  always_comb begin
    sout_valid = !reset && (state_q == SHIFT);
    busy       = sout_valid;
    sout       = sout_valid ? cur_bit : IDLE_BIT;
    word_done  = sout_valid && (cnt_q == '0);
  end

endmodule
